exception_ctrl: RTL
===================

EXCEPTION_CTRL -- requirements
Module: exception_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-002 The block SHALL have these inputs:
- int_req  in  6  hardware interrupt lines, level-sensitive
- int_mask  in  6  Status.IM
- ie  in  1  Status.IE
- id_syscall  in  1  syscall decoded in ID
- id_unknown  in  1  reserved instruction in ID
- exe_overflow  in  1  arithmetic overflow in EXE
- id_eret  in  1  eret decoded in ID
- stall  in  1  pipeline stall; freezes event sampling
REQ-003 The block SHALL have these outputs:
- epc_we  out  1  EPC write strobe; EPC data comes from the EPC mux
- cause_we  out  1  Cause.ExcCode write strobe
- cause_code  out  5  ExcCode value, valid with cause_we
- exl  out  1  Status.EXL, registered
- flush_if, flush_id, flush_exe  out  1 each  stage flushes
- pc_sel  out  2  00 = sequential, 01 = handler vector 0x0000_0004, 10 = EPC
- int_ack  out  1  interrupt taken; one-cycle pulse

Function
REQ-004 The states SHALL be IDLE, HANDLER and DRAIN, held in a registered state variable.
REQ-005 The pending interrupt register int_pend[5:0] SHALL update every cycle as int_pend <= (int_pend | int_req) & int_mask.
- On a trap taken for cause Int, it SHALL clear to 0 at the next edge.
REQ-006 The trap condition SHALL be evaluated only in IDLE with stall=0. Priority, highest first:
- exe_overflow gives code 12
- id_syscall gives code 8
- id_unknown gives code 10
- (|int_pend) & ie gives code 0
REQ-007 In the detection cycle, the block SHALL drive the following combinationally:
- epc_we=1, cause_we=1, cause_code per REQ-006
- flush_if=flush_id=1
- flush_exe=1 only for overflow
- pc_sel=01
- int_ack=1 only for code 0
- next state = HANDLER
REQ-008 In HANDLER, exl SHALL be 1 and all further traps SHALL be ignored; no nesting. int_pend SHALL continue to accumulate.
REQ-009 In HANDLER with id_eret=1 and stall=0, the block SHALL drive pc_sel=10 and flush_if=1 in that cycle, and the next state SHALL be DRAIN.
REQ-010 In DRAIN, the block SHALL drive flush_id=1 for exactly one cycle, hold exl=1, take no traps, and move to IDLE. exl SHALL read 0 from the cycle after DRAIN.
REQ-011 When no condition in REQ-007 or REQ-009 applies, all strobes and flushes SHALL be 0, pc_sel SHALL be 00, and cause_code SHALL be 0.
REQ-012 With stall=1, the state, exl and all strobes SHALL hold at their non-asserted values. Trap and eret detection SHALL be deferred, not lost, because the ID/EXE inputs persist while stalled.
REQ-013 id_eret in IDLE SHALL be treated as a no-op; reserved-instruction handling is decode's responsibility.
REQ-014 Detection in IDLE SHALL be latency 0 (same cycle). exl SHALL rise at the following edge.

Reset
REQ-015 When rst=1 at a clock edge, the block SHALL set state=IDLE, exl=0 and int_pend=0, overriding all other inputs including a trap in the same cycle.
REQ-016 During a reset cycle, all combinational outputs SHALL be forced to their REQ-011 values.
REQ-017 A reset asserted in HANDLER or DRAIN SHALL return the block to IDLE, with exl=0 on the next cycle.

Configuration
REQ-018 Macro EXC_EXTINT_EN SHALL control external interrupt support.
- Defined: external interrupts operate per REQ-005 and REQ-006.
- Undefined: int_req, int_mask and ie are ignored, int_pend is constant 0, int_ack is constant 0, and only synchronous exceptions trap.

Verification
REQ-019 Overflow priority: in IDLE, exe_overflow=1 and id_syscall=1 in the same cycle -> cause_code=12, epc_we=1, flush_if/id/exe=1, pc_sel=01; exl=1 on the next cycle.
REQ-020 Interrupt: int_mask=6'b000001, ie=1, pulse int_req[0] for 1 cycle -> trap with code 0 and int_ack=1 on the following cycle; int_pend=0 after.
REQ-021 Blocking in handler: in HANDLER, assert id_syscall -> no epc_we; then id_eret -> pc_sel=10, flush_if=1, then DRAIN with flush_id=1, then exl=0.
REQ-022 Stall deferral: id_unknown=1 with stall=1 for 3 cycles -> no strobes; stall drops -> cause_code=10 in that cycle.
REQ-023 Reset mid-handler: rst=1 in HANDLER with int_pend=6'h3F -> next cycle state=IDLE, exl=0, int_pend=0, no trap.
REQ-024 Macro off: EXC_EXTINT_EN undefined, int_req=6'h3F, ie=1, int_mask=6'h3F for 10 cycles -> epc_we stays 0.

Source files
------------

// File: rtl/exception_ctrl_if.sv
// Pipeline <-> exception controller signal bundle: event inputs, trap strobes, flushes, PC select.
// Master is the pipeline side that drives events; slave is exception_ctrl.
interface exception_ctrl_if;
  logic [5:0] int_req;
  logic [5:0] int_mask;
  logic       ie;
  logic       id_syscall;
  logic       id_unknown;
  logic       exe_overflow;
  logic       id_eret;
  logic       stall;

  logic       epc_we;
  logic       cause_we;
  logic [4:0] cause_code;
  logic       exl;
  logic       flush_if;
  logic       flush_id;
  logic       flush_exe;
  logic [1:0] pc_sel;
  logic       int_ack;

  modport master (
    output int_req, int_mask, ie, id_syscall, id_unknown, exe_overflow, id_eret, stall,
    input  epc_we, cause_we, cause_code, exl, flush_if, flush_id, flush_exe, pc_sel, int_ack
  );

  modport slave (
    input  int_req, int_mask, ie, id_syscall, id_unknown, exe_overflow, id_eret, stall,
    output epc_we, cause_we, cause_code, exl, flush_if, flush_id, flush_exe, pc_sel, int_ack
  );
endinterface

// File: rtl/exception_ctrl.sv
// Trap/eret sequencer (IDLE/HANDLER/DRAIN); external interrupts only when EXC_EXTINT_EN is defined.
// Latency: trap and eret decisions are combinational in the detection cycle; exl follows one edge later.
// Backpressure: stall freezes state and suppresses all strobes; held ID/EXE events are taken once it drops.
module exception_ctrl (
  input  logic            clk,
  input  logic            rst,
  exception_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, HANDLER, DRAIN} state_t;

  localparam logic [4:0] CODE_INT = 5'd0;
  localparam logic [4:0] CODE_SYS = 5'd8;
  localparam logic [4:0] CODE_RI  = 5'd10;
  localparam logic [4:0] CODE_OV  = 5'd12;

  state_t     state;
  logic       exl_q;
  logic [5:0] int_pend;
  logic       int_hit;
  logic       trap;
  logic       int_take;
  logic [4:0] code;
  logic       eret_take;
  logic       drain_take;

`ifdef EXC_EXTINT_EN
  assign int_hit = (|int_pend) & bus.ie;

  // Pending lines keep accumulating in every state; only a taken interrupt clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      int_pend <= '0;
    end else if (int_take) begin
      int_pend <= '0;
    end else begin
      int_pend <= (int_pend | bus.int_req) & bus.int_mask;
    end
  end
`else
  assign int_hit  = 1'b0;
  assign int_pend = '0;
`endif

  always_comb begin
    trap     = 1'b0;
    int_take = 1'b0;
    code     = CODE_INT;
    if (!rst && state == IDLE && !bus.stall) begin
      if (bus.exe_overflow) begin
        trap = 1'b1;
        code = CODE_OV;
      end else if (bus.id_syscall) begin
        trap = 1'b1;
        code = CODE_SYS;
      end else if (bus.id_unknown) begin
        trap = 1'b1;
        code = CODE_RI;
      end else if (int_hit) begin
        trap     = 1'b1;
        int_take = 1'b1;
        code     = CODE_INT;
      end
    end
  end

  assign eret_take  = !rst && state == HANDLER && bus.id_eret && !bus.stall;
  assign drain_take = !rst && state == DRAIN && !bus.stall;

  assign bus.epc_we     = trap;
  assign bus.cause_we   = trap;
  assign bus.cause_code = code;
  assign bus.flush_if   = trap | eret_take;
  assign bus.flush_id   = trap | drain_take;
  assign bus.flush_exe  = trap & bus.exe_overflow;
  assign bus.pc_sel     = trap ? 2'b01 : (eret_take ? 2'b10 : 2'b00);
  assign bus.int_ack    = int_take;
  assign bus.exl        = exl_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      exl_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (trap) begin
            state <= HANDLER;
            exl_q <= 1'b1;
          end
        end
        HANDLER: begin
          if (eret_take) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_take) begin
            state <= IDLE;
            exl_q <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          exl_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
